// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the hazard scheduler.
//   state_e     : sequencer state (RUN / MEM_WAIT)
//   FWD_*       : operand forwarding-select codes
//   src_hit()   : "this decode source is in use and names that register"
package hazard_scheduler_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_MEM = 2'b01;  // MEM-stage ALU result
    localparam logic [1:0] FWD_WB  = 2'b10;  // WB-stage value

    function automatic logic src_hit(input logic [3:0] src,
                                     input logic       used,
                                     input logic [3:0] dest);
        return used && (src == dest);
    endfunction

endpackage

// File: rtl/hazard_scheduler_forward_select.sv
// Per-operand forwarding mux select. Purely combinational.
//   fwd_en              : forwarding globally enabled
//   exe_src             : operand source register latched in ID/EX
//   mem_dest/mem_wb_en  : MEM-stage producer
//   wb_dest/wb_wb_en    : WB-stage producer
//   sel                 : FWD_RF / FWD_MEM / FWD_WB
module forward_select
    import hazard_scheduler_pkg::*;
(
    input  logic       fwd_en,
    input  logic [3:0] exe_src,
    input  logic [3:0] mem_dest,
    input  logic       mem_wb_en,
    input  logic [3:0] wb_dest,
    input  logic       wb_wb_en,
    output logic [1:0] sel
);

    // MEM is the younger producer, so it wins over WB.
    always_comb begin
        sel = FWD_RF;
        if (fwd_en) begin
            if (mem_wb_en && (exe_src == mem_dest))
                sel = FWD_MEM;
            else if (wb_wb_en && (exe_src == wb_dest))
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline sequencer for the 5-stage core: decode bubble (hazard), operand
// forwarding selects, branch flushes and whole-pipe freeze on slow data
// memory accesses, with a memory-wait timeout and a stall-cycle counter.
//   clk, rst                 : clock, async active-low reset
//   fwd_en                   : forwarding enable
//   id_*                     : decode-stage sources and usage flags
//   exe_*                    : execute-stage sources/dest/controls/branch
//   mem_*, wb_*              : later-stage producers, memory handshake
//   hazard                   : insert bubble in decode
//   freeze_all               : hold all pipeline registers and PC
//   flush_if_id, flush_id_ex : clear front-end registers
//   sel_src1, sel_src2       : forwarding selects
//   mem_err                  : sticky memory timeout
//   stall_cnt                : saturating stalled-cycle count
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_use_src1,
    input  logic [3:0]       exe_src1,
    input  logic [3:0]       exe_src2,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic             exe_branch,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    output logic             hazard,
    output logic             freeze_all,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};

    state_e               state, state_nxt;
    logic [TIMEOUT_W-1:0] timer, timer_nxt;
    logic                 err_set;

    // ---------------- memory-wait FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            timer   <= '0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (err_set)
                mem_err <= 1'b1;
        end
    end

    // Freeze is combinational so the very first cycle of a slow access is
    // already held; the cycle mem_ready rises runs normally.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        err_set    = 1'b0;
        freeze_all = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze_all = 1'b1;
                    state_nxt  = MEM_WAIT;
                    timer_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                freeze_all = !mem_ready;
                if (mem_ready) begin
                    state_nxt = RUN;
                end else if (timer == TIMER_LAST) begin
                    // Abort: release the pipe and flag the error.
                    state_nxt = RUN;
                    err_set   = 1'b1;
                end else begin
                    timer_nxt = timer + TIMEOUT_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // ---------------- decode hazard ----------------
    logic hit_exe, hit_mem, hazard_raw;

    assign hit_exe = src_hit(id_src1, id_use_src1, exe_dest) |
                     src_hit(id_src2, id_two_src,  exe_dest);
    assign hit_mem = src_hit(id_src1, id_use_src1, mem_dest) |
                     src_hit(id_src2, id_two_src,  mem_dest);

    // Without forwarding any in-flight writer blocks decode; with it only a
    // load in EXE does (its data is not available until after MEM).
    assign hazard_raw = fwd_en ? (hit_exe & exe_mem_r_en)
                               : ((hit_exe & exe_wb_en) | (hit_mem & mem_wb_en));

    // Freeze beats branch beats hazard. A branch held in a frozen ID/EX
    // flushes on the first unfrozen cycle.
    assign hazard      = hazard_raw & !freeze_all & !exe_branch;
    assign flush_if_id = exe_branch & !freeze_all;
    assign flush_id_ex = exe_branch & !freeze_all;

    // ---------------- forwarding ----------------
    forward_select u_fwd1 (
        .fwd_en    (fwd_en),
        .exe_src   (exe_src1),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .wb_dest   (wb_dest),
        .wb_wb_en  (wb_wb_en),
        .sel       (sel_src1)
    );

    forward_select u_fwd2 (
        .fwd_en    (fwd_en),
        .exe_src   (exe_src2),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .wb_dest   (wb_dest),
        .wb_wb_en  (wb_wb_en),
        .sel       (sel_src2)
    );

    // ---------------- stall counter ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if ((freeze_all || hazard) && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler with a behavioural reference model
// checked every cycle plus literal expectations per scenario.
module tb_hazard_scheduler;

    localparam int TW   = 8;
    localparam int TO   = 8;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic fwd_en, id_two_src, id_use_src1;
    logic [3:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
    logic exe_wb_en, exe_mem_r_en, exe_branch, mem_wb_en, mem_req, mem_ready, wb_wb_en;
    logic hazard, freeze_all, flush_if_id, flush_id_ex, mem_err;
    logic [1:0] sel_src1, sel_src2;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_scheduler #(.TIMEOUT_W(TW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_use_src1(id_use_src1),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_branch(exe_branch),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
        .mem_ready(mem_ready), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .hazard(hazard), .freeze_all(freeze_all),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_wait;     // a slow access is outstanding
    int m_waited;   // cycles already spent waiting after the first one
    bit m_err;
    int m_stall;
    bit m_f, m_h;

    function automatic bit exp_freeze();
        if (m_wait) return !mem_ready;
        return mem_req && !mem_ready;
    endfunction

    function automatic bit exp_hazard();
        bit h = 0;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] s = (i == 0) ? id_src1 : id_src2;
            bit on = (i == 0) ? id_use_src1 : id_two_src;
            if (on) begin
                if (fwd_en) begin
                    if (s == exe_dest && exe_mem_r_en) h = 1;
                end else begin
                    if (s == exe_dest && exe_wb_en) h = 1;
                    if (s == mem_dest && mem_wb_en) h = 1;
                end
            end
        end
        if (exp_freeze() || exe_branch) h = 0;
        return h;
    endfunction

    function automatic int exp_sel(input logic [3:0] s);
        if (!fwd_en) return 0;
        if (mem_wb_en && s == mem_dest) return 1;
        if (wb_wb_en && s == wb_dest) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0;
        end else begin
            m_f = exp_freeze();
            m_h = exp_hazard();
            if ((m_f || m_h) && m_stall < CMAX) m_stall++;
            if (!m_wait) begin
                if (mem_req && !mem_ready) begin m_wait = 1; m_waited = 0; end
            end else if (mem_ready) begin
                m_wait = 0;
            end else begin
                m_waited++;
                if (m_waited == TO) begin m_wait = 0; m_err = 1; end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_freeze",  freeze_all,  exp_freeze());
        chk("m_hazard",  hazard,      exp_hazard());
        chk("m_flush1",  flush_if_id, exe_branch && !exp_freeze());
        chk("m_flush2",  flush_id_ex, exe_branch && !exp_freeze());
        chk("m_sel1",    sel_src1,    exp_sel(exe_src1));
        chk("m_sel2",    sel_src2,    exp_sel(exe_src2));
        chk("m_err",     mem_err,     m_err);
        chk("m_stall",   stall_cnt,   m_stall);
    end

    // ---------------- stimulus ----------------
    task automatic tick(); @(posedge clk); #1; endtask
    task automatic look(); @(negedge clk); #1; endtask

    task automatic clear();
        fwd_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_use_src1 = 0;
        exe_src1 = 0; exe_src2 = 0; exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
        exe_branch = 0; mem_dest = 0; mem_wb_en = 0; mem_req = 0; mem_ready = 0;
        wb_dest = 0; wb_wb_en = 0;
    endtask

    task automatic do_reset();
        clear();
        rst = 0;
        tick(); tick();
        rst = 1;
    endtask

    initial begin
        clear();
        #1;
        chk("rst_freeze", freeze_all, 0);
        chk("rst_err",    mem_err,    0);
        chk("rst_stall",  stall_cnt,  0);
        tick(); rst = 1;

        // forwarding disabled vs enabled, plain ALU producer in EXE
        do_reset(); tick();
        exe_dest = 3; exe_wb_en = 1; id_src1 = 3; id_use_src1 = 1;
        look(); chk("nofwd_hazard", hazard, 1); chk("nofwd_sel1", sel_src1, 0);
        tick(); fwd_en = 1;
        look(); chk("fwd_hazard", hazard, 0);

        // load-use
        do_reset(); tick();
        fwd_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; id_src2 = 5; id_two_src = 1;
        look(); chk("lu_hazard", hazard, 1); chk("lu_stall0", stall_cnt, 0);
        tick(); exe_mem_r_en = 0; exe_wb_en = 0; exe_dest = 0;
        look(); chk("lu_bubble", hazard, 0); chk("lu_stall1", stall_cnt, 1);

        // forwarding priority
        tick(); clear();
        fwd_en = 1; exe_src1 = 2; exe_src2 = 2; mem_dest = 2; wb_dest = 2;
        mem_wb_en = 1; wb_wb_en = 1;
        look(); chk("pri_mem1", sel_src1, 1); chk("pri_mem2", sel_src2, 1);
        tick(); mem_wb_en = 0;
        look(); chk("pri_wb1", sel_src1, 2);
        tick(); fwd_en = 0;
        look(); chk("pri_off", sel_src1, 0);

        // memory wait, 4 cycles
        do_reset(); tick();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            look(); chk("mw_frozen", freeze_all, 1); tick();
        end
        mem_ready = 1;
        look(); chk("mw_ready", freeze_all, 0);
        tick(); mem_req = 0; mem_ready = 0;
        look(); chk("mw_run", freeze_all, 0); chk("mw_err", mem_err, 0);
        chk("mw_stall", stall_cnt, 4);

        // timeout
        do_reset(); tick();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 9; i++) begin
            look(); chk("to_frozen", freeze_all, 1); chk("to_err0", mem_err, 0); tick();
        end
        mem_req = 0;
        look(); chk("to_free", freeze_all, 0); chk("to_err1", mem_err, 1);
        tick(); tick(); tick();
        look(); chk("to_sticky", mem_err, 1);
        do_reset();
        look(); chk("to_cleared", mem_err, 0);

        // stall counter saturation
        do_reset(); tick();
        mem_req = 1; mem_ready = 0;
        repeat (20) tick();
        mem_req = 0;
        look(); chk("sat_stall", stall_cnt, 15);

        // branch during freeze
        do_reset(); tick();
        mem_req = 1; mem_ready = 0; exe_branch = 1;
        exe_dest = 3; exe_wb_en = 1; id_src1 = 3; id_use_src1 = 1;
        for (int i = 0; i < 2; i++) begin
            look(); chk("br_frz_flush", flush_if_id, 0); chk("br_frz_flush2", flush_id_ex, 0);
            chk("br_frz_haz", hazard, 0); tick();
        end
        mem_ready = 1;
        look(); chk("br_flush1", flush_if_id, 1); chk("br_flush2", flush_id_ex, 1);
        chk("br_haz", hazard, 0); chk("br_unfrz", freeze_all, 0);
        tick(); exe_branch = 0; mem_req = 0; mem_ready = 0;
        look(); chk("br_done", flush_if_id, 0); chk("br_haz_back", hazard, 1);

        // reset asserted mid-wait
        do_reset(); tick();
        mem_req = 1; mem_ready = 0;
        look(); tick(); look();
        rst = 0; #1;
        chk("mid_freeze_live", freeze_all, 1); chk("mid_stall", stall_cnt, 0);
        mem_req = 0; #1;
        chk("mid_freeze_off", freeze_all, 0);
        rst = 1;
        tick(); look(); chk("mid_run", freeze_all, 0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
